// File: rtl/rl_pkg.sv
// Shared types and helpers for the Q-table write-back path: fixed-point
// format, FSM state encoding, saturation and unit clamp.
package rl_pkg;

    // Default Q word width. Modules that take a WIDTH parameter must keep it equal to Q_W.
    localparam int Q_W   = 16;
    localparam int FRAC  = Q_W / 2;
    // Internal TD width: wide enough that no intermediate is truncated.
    localparam int ACC_W = Q_W + FRAC + 3;

    typedef logic signed [Q_W-1:0] q_t;

    typedef enum logic [2:0] {
        CLEAR = 3'd0,
        IDLE  = 3'd1,
        READ  = 3'd2,
        CALC  = 3'd3,
        WRITE = 3'd4
    } upd_state_e;

    // Saturate a wide signed TD result to the Q range.
    function automatic q_t sat_q(input logic signed [ACC_W-1:0] v);
        logic signed [ACC_W-1:0] max_v;
        logic signed [ACC_W-1:0] min_v;
        max_v = {{(ACC_W-Q_W+1){1'b0}}, {(Q_W-1){1'b1}}};
        min_v = {{(ACC_W-Q_W+1){1'b1}}, {(Q_W-1){1'b0}}};
        if (v > max_v)
            sat_q = max_v[Q_W-1:0];
        else if (v < min_v)
            sat_q = min_v[Q_W-1:0];
        else
            sat_q = v[Q_W-1:0];
    endfunction

    // Clamp an unsigned learning/discount rate to at most 1.0 (1 << FRAC).
    function automatic logic [Q_W-1:0] clamp_unit(input logic [Q_W-1:0] v);
        logic [Q_W-1:0] one;
        one = Q_W'(1) << FRAC;
        clamp_unit = (v > one) ? one : v;
    endfunction

endpackage

// File: rtl/q_td_alu.sv
// Combinational temporal-difference step:
// q_new = sat(q_old + ((alpha * (r + ((gamma*next_max)>>>FRAC) - q_old)) >>> FRAC)).
// alpha and gamma arrive already clamped to [0, 1.0].
module q_td_alu
    import rl_pkg::*;
#(
    parameter int WIDTH = Q_W
) (
    input  logic signed [WIDTH-1:0] q_old,
    input  logic signed [WIDTH-1:0] reward,
    input  logic signed [WIDTH-1:0] next_max,
    input  logic        [WIDTH-1:0] alpha,
    input  logic        [WIDTH-1:0] gamma,
    output logic signed [WIDTH-1:0] q_new
);

    localparam int AW = ACC_W;

    logic signed [AW-1:0] q_x;
    logic signed [AW-1:0] r_x;
    logic signed [AW-1:0] nm_x;
    logic signed [AW-1:0] a_x;
    logic signed [AW-1:0] g_x;
    logic signed [AW-1:0] disc;
    logic signed [AW-1:0] target;
    logic signed [AW-1:0] delta;
    logic signed [AW-1:0] prod;
    logic signed [AW-1:0] sum;

    // Extend everything to the internal width, then apply the TD rule; shifts floor toward -inf.
    always_comb begin
        q_x    = {{(AW-WIDTH){q_old[WIDTH-1]}}, q_old};
        r_x    = {{(AW-WIDTH){reward[WIDTH-1]}}, reward};
        nm_x   = {{(AW-WIDTH){next_max[WIDTH-1]}}, next_max};
        a_x    = {{(AW-WIDTH){1'b0}}, alpha};
        g_x    = {{(AW-WIDTH){1'b0}}, gamma};
        disc   = g_x * nm_x;
        target = r_x + (disc >>> FRAC);
        delta  = target - q_x;
        prod   = a_x * delta;
        sum    = q_x + (prod >>> FRAC);
        q_new  = sat_q(sum);
    end

endmodule

// File: rtl/q_table_updater.sv
// Q-table owner: flop-array table, registered full-row read port, and a
// CLEAR/IDLE/READ/CALC/WRITE sequencer that retires one TD update per 4 cycles.
// Handshake: an update transfers on a rising edge where upd_valid && upd_ready;
// upd_ready is high only in IDLE, and upstream holds upd_valid and all upd_*
// fields stable until that edge.
module q_table_updater
    import rl_pkg::*;
#(
    parameter int              WIDTH   = Q_W,
    parameter int              ACTIONS = 4,
    parameter int              STATES  = 16,
    parameter logic [WIDTH-1:0] INIT_Q = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       upd_valid,
    output logic                       upd_ready,
    input  logic [$clog2(STATES)-1:0]  upd_state,
    input  logic [$clog2(ACTIONS)-1:0] upd_action,
    input  logic [WIDTH-1:0]           upd_reward,
    input  logic [WIDTH-1:0]           upd_next_max,
    input  logic [WIDTH-1:0]           alpha,
    input  logic [WIDTH-1:0]           gamma,
    input  logic [$clog2(STATES)-1:0]  rd_state,
    output logic [ACTIONS*WIDTH-1:0]   rd_q,
    output logic                       done_valid,
    output logic [WIDTH-1:0]           done_q,
    output logic                       done_err,
    output logic                       busy,
    output upd_state_e                 fsm_state
);

    localparam int SW  = $clog2(STATES);
    localparam int AIW = $clog2(ACTIONS);

    logic [WIDTH-1:0] tbl [STATES][ACTIONS];

    upd_state_e       state;
    logic [SW-1:0]    row_cnt;
    logic [SW-1:0]    lat_s;
    logic [AIW-1:0]   lat_a;
    logic [WIDTH-1:0] lat_r;
    logic [WIDTH-1:0] lat_nm;
    logic [WIDTH-1:0] lat_alpha;
    logic [WIDTH-1:0] lat_gamma;
    logic             lat_err;
    logic [WIDTH-1:0] q_old;
    logic [WIDTH-1:0] q_calc;
    logic [WIDTH-1:0] alu_q;
    logic             upd_err;
    logic             rd_ok;

    assign fsm_state = state;
    assign upd_err   = (32'(upd_state) >= STATES) || (32'(upd_action) >= ACTIONS);
    assign rd_ok     = (32'(rd_state) < STATES);

    q_td_alu #(.WIDTH(WIDTH)) u_alu (
        .q_old    (q_old),
        .reward   (lat_r),
        .next_max (lat_nm),
        .alpha    (lat_alpha),
        .gamma    (lat_gamma),
        .q_new    (alu_q)
    );

    // Update sequencer with registered handshake/status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= CLEAR;
            row_cnt    <= '0;
            upd_ready  <= 1'b0;
            busy       <= 1'b0;
            done_valid <= 1'b0;
            done_q     <= '0;
            done_err   <= 1'b0;
            lat_s      <= '0;
            lat_a      <= '0;
            lat_r      <= '0;
            lat_nm     <= '0;
            lat_alpha  <= '0;
            lat_gamma  <= '0;
            lat_err    <= 1'b0;
            q_old      <= '0;
            q_calc     <= '0;
        end else begin
            done_valid <= 1'b0;
            case (state)
                CLEAR: begin
                    if (row_cnt == SW'(STATES - 1)) begin
                        state     <= IDLE;
                        upd_ready <= 1'b1;
                        busy      <= 1'b0;
                    end else begin
                        row_cnt <= row_cnt + 1'b1;
                        busy    <= 1'b1;
                    end
                end
                IDLE: begin
                    if (upd_valid) begin
                        lat_s     <= upd_state;
                        lat_a     <= upd_action;
                        lat_r     <= upd_reward;
                        lat_nm    <= upd_next_max;
                        lat_alpha <= clamp_unit(alpha);
                        lat_gamma <= clamp_unit(gamma);
                        lat_err   <= upd_err;
                        upd_ready <= 1'b0;
                        busy      <= 1'b1;
                        state     <= READ;
                    end
                end
                READ: begin
                    q_old <= lat_err ? '0 : tbl[lat_s][lat_a];
                    state <= CALC;
                end
                CALC: begin
                    q_calc <= alu_q;
                    state  <= WRITE;
                end
                WRITE: begin
                    done_valid <= 1'b1;
                    done_q     <= lat_err ? '0 : q_calc;
                    done_err   <= lat_err;
                    upd_ready  <= 1'b1;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    state   <= CLEAR;
                    row_cnt <= '0;
                end
            endcase
        end
    end

    // Table storage: row-at-a-time clear, then single-entry TD write-back.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == CLEAR) begin
                for (int i = 0; i < ACTIONS; i++)
                    tbl[row_cnt][i] <= INIT_Q;
            end else if (state == WRITE && !lat_err) begin
                tbl[lat_s][lat_a] <= q_calc;
            end
        end
    end

    // Registered full-row read; out-of-range rows read as zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q <= '0;
        end else begin
            for (int i = 0; i < ACTIONS; i++)
                rd_q[i*WIDTH +: WIDTH] <= rd_ok ? tbl[rd_state][i] : '0;
        end
    end

endmodule

// File: tb/tb_q_table_updater.sv
// Self-checking bench for q_table_updater: directed vector table, multi-cycle
// corner sequences and randomized updates against a plain-arithmetic model.
module tb_q_table_updater;

  logic        clk;
  logic        rst;
  logic        upd_valid;
  logic        b_valid;
  logic [3:0]  upd_state;
  logic [1:0]  upd_action;
  logic [15:0] upd_reward;
  logic [15:0] upd_next_max;
  logic [15:0] alpha;
  logic [15:0] gamma;
  logic [3:0]  rd_state;

  logic        upd_ready, done_valid, done_err, busy;
  logic [63:0] rd_q;
  logic [15:0] done_q;
  rl_pkg::upd_state_e fsm_state;

  logic        b_ready, b_done_valid, b_done_err, b_busy;
  logic [47:0] b_rd_q;
  logic [15:0] b_done_q;
  rl_pkg::upd_state_e b_fsm_state;

  int checks = 0;
  int errors = 0;

  logic signed [15:0] model_q [16][4];
  logic [15:0] exp_q [$];

  typedef struct {
    logic [3:0]  s;
    logic [1:0]  a;
    logic [15:0] r;
    logic [15:0] nm;
    logic [15:0] al;
    logic [15:0] ga;
    logic [15:0] exp_q;
  } vec_t;

  vec_t vecs [9];

  q_table_updater dut (
    .clk(clk), .rst(rst), .upd_valid(upd_valid), .upd_ready(upd_ready),
    .upd_state(upd_state), .upd_action(upd_action), .upd_reward(upd_reward),
    .upd_next_max(upd_next_max), .alpha(alpha), .gamma(gamma),
    .rd_state(rd_state), .rd_q(rd_q), .done_valid(done_valid), .done_q(done_q),
    .done_err(done_err), .busy(busy), .fsm_state(fsm_state)
  );

  q_table_updater #(.ACTIONS(3)) dut3 (
    .clk(clk), .rst(rst), .upd_valid(b_valid), .upd_ready(b_ready),
    .upd_state(upd_state), .upd_action(upd_action), .upd_reward(upd_reward),
    .upd_next_max(upd_next_max), .alpha(alpha), .gamma(gamma),
    .rd_state(rd_state), .rd_q(b_rd_q), .done_valid(b_done_valid), .done_q(b_done_q),
    .done_err(b_done_err), .busy(b_busy), .fsm_state(b_fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // reference model: TD rule in plain integer arithmetic, floor shifts, clamp, saturate
  function automatic logic [15:0] model_td(input logic signed [15:0] q, input logic signed [15:0] r,
                                           input logic signed [15:0] nm, input logic [15:0] al,
                                           input logic [15:0] ga);
    longint a_l, g_l, t, d, n;
    a_l = (al > 16'h0100) ? 256 : longint'(al);
    g_l = (ga > 16'h0100) ? 256 : longint'(ga);
    t = longint'(r) + ((g_l * longint'(nm)) >>> 8);
    d = t - longint'(q);
    n = longint'(q) + ((a_l * d) >>> 8);
    if (n > 32767) n = 32767;
    if (n < -32768) n = -32768;
    return n[15:0];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 4; j++)
        model_q[i][j] = '0;
  endtask

  // driver: one update on dut (sel=0) or dut3 (sel=1); lat counts cycles from handshake to done
  task automatic run_upd(input bit sel, input logic [3:0] s, input logic [1:0] a,
                         input logic [15:0] r, input logic [15:0] nm, input logic [15:0] al,
                         input logic [15:0] ga, output logic [15:0] q, output logic e,
                         output int lat);
    int n;
    upd_state = s; upd_action = a; upd_reward = r; upd_next_max = nm;
    alpha = al; gamma = ga;
    if (sel) b_valid = 1'b1; else upd_valid = 1'b1;
    n = 0;
    while (!(sel ? b_ready : upd_ready) && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) chk("ready_timeout", 64'd0, 64'd1);
    tick();
    upd_valid = 1'b0;
    b_valid = 1'b0;
    alpha = 16'(~al);
    gamma = 16'(~ga);
    lat = 0;
    while (!(sel ? b_done_valid : done_valid) && lat < 10) begin
      tick();
      lat++;
    end
    q = sel ? b_done_q : done_q;
    e = sel ? b_done_err : done_err;
  endtask

  task automatic count_clear(input string name);
    int n;
    int seen_done;
    n = 0;
    seen_done = 0;
    while (!upd_ready && n < 40) begin
      tick();
      if (done_valid) seen_done++;
      n++;
    end
    chk({name, "_ready_low_cycles"}, 64'(n), 64'd16);
    chk({name, "_no_done"}, 64'(seen_done), 64'd0);
  endtask

  task automatic check_all_rows(input string name);
    logic [63:0] row;
    for (int i = 0; i < 16; i++) begin
      rd_state = 4'(i);
      tick();
      row = {model_q[i][3], model_q[i][2], model_q[i][1], model_q[i][0]};
      chk(name, rd_q, row);
    end
  endtask

  initial begin
    logic [15:0] q;
    logic        e;
    int          lat;
    logic [15:0] old_v;
    logic [15:0] new_v;

    rst = 1'b1; upd_valid = 1'b0; b_valid = 1'b0;
    upd_state = '0; upd_action = '0; upd_reward = '0; upd_next_max = '0;
    alpha = '0; gamma = '0; rd_state = '0;
    model_clear();

    vecs[0] = '{4'd3, 2'd1, 16'h0100, 16'h0200, 16'h0080, 16'h0080, 16'h0100};
    vecs[1] = '{4'd3, 2'd1, 16'h0100, 16'h0200, 16'h0080, 16'h0080, 16'h0180};
    vecs[2] = '{4'd5, 2'd0, 16'h7F00, 16'h0000, 16'h0100, 16'h0000, 16'h7F00};
    vecs[3] = '{4'd5, 2'd0, 16'h7FFF, 16'h7FFF, 16'h0100, 16'h0100, 16'h7FFF};
    vecs[4] = '{4'd6, 2'd2, 16'h8000, 16'h8000, 16'h0100, 16'h0100, 16'h8000};
    vecs[5] = '{4'd7, 2'd3, 16'h0400, 16'h0000, 16'hFFFF, 16'h0000, 16'h0400};
    vecs[6] = '{4'd7, 2'd3, 16'h0200, 16'h0000, 16'hFFFF, 16'hFFFF, 16'h0200};
    vecs[7] = '{4'd8, 2'd0, 16'h0100, 16'h0100, 16'hFFFF, 16'hFFFF, 16'h0200};
    vecs[8] = '{4'd9, 2'd1, 16'hFFFF, 16'h0001, 16'h0080, 16'h0080, 16'hFFFF};

    // 1. reset state and clear duration
    tick(); tick();
    chk("rst_upd_ready", 64'(upd_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done_valid", 64'(done_valid), 64'd0);
    chk("rst_rd_q", rd_q, 64'd0);
    rst = 1'b0;
    count_clear("init");
    check_all_rows("init_row");

    // 2/3. directed vector table
    for (int i = 0; i < 9; i++) begin
      run_upd(1'b0, vecs[i].s, vecs[i].a, vecs[i].r, vecs[i].nm, vecs[i].al, vecs[i].ga, q, e, lat);
      chk($sformatf("vec%0d_done_q", i), 64'(q), 64'(vecs[i].exp_q));
      chk($sformatf("vec%0d_err", i), 64'(e), 64'd0);
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd3);
      model_q[vecs[i].s][vecs[i].a] = vecs[i].exp_q;
    end
    tick();
    chk("done_pulse_one_cycle", 64'(done_valid), 64'd0);
    rd_state = 4'd3;
    tick();
    chk("row3_after_updates", rd_q, 64'h0000_0000_0180_0000);

    // 4. back-to-back with upd_valid held; alpha scrambled mid-flight
    begin
      logic [3:0]  bs [3];
      logic [1:0]  ba [3];
      logic [15:0] br [3], bn [3], bal [3], bga [3];
      int hs_cnt, done_cnt, last_hs;
      bit hs, fix_pending;
      for (int k = 0; k < 3; k++) begin
        bs[k] = 4'($urandom_range(0, 15)); ba[k] = 2'($urandom_range(0, 3));
        br[k] = 16'($urandom); bn[k] = 16'($urandom);
        bal[k] = 16'($urandom_range(0, 16'h0180)); bga[k] = 16'($urandom_range(0, 16'h0180));
      end
      upd_state = bs[0]; upd_action = ba[0]; upd_reward = br[0]; upd_next_max = bn[0];
      alpha = bal[0]; gamma = bga[0];
      upd_valid = 1'b1;
      hs_cnt = 0; done_cnt = 0; last_hs = 0; fix_pending = 0;
      for (int cyc = 0; cyc < 40; cyc++) begin
        hs = upd_valid && upd_ready;
        if (hs) begin
          q = model_td(model_q[upd_state][upd_action], upd_reward, upd_next_max, alpha, gamma);
          model_q[upd_state][upd_action] = q;
          exp_q.push_back(q);
        end
        tick();
        if (done_valid) begin
          done_cnt++;
          if (exp_q.size() > 0) chk("b2b_done_q", 64'(done_q), 64'(exp_q.pop_front()));
          else chk("b2b_unexpected_done", 64'd1, 64'd0);
        end
        if (hs) begin
          if (hs_cnt > 0) chk("b2b_handshake_gap", 64'(cyc - last_hs), 64'd4);
          last_hs = cyc;
          hs_cnt++;
          alpha = 16'($urandom);
          gamma = 16'($urandom);
          if (hs_cnt == 3) upd_valid = 1'b0;
          else begin
            upd_state = bs[hs_cnt]; upd_action = ba[hs_cnt];
            upd_reward = br[hs_cnt]; upd_next_max = bn[hs_cnt];
            fix_pending = 1;
          end
        end else if (fix_pending && cyc >= last_hs + 2) begin
          alpha = bal[hs_cnt]; gamma = bga[hs_cnt];
          fix_pending = 0;
        end
      end
      chk("b2b_handshakes", 64'(hs_cnt), 64'd3);
      chk("b2b_done_pulses", 64'(done_cnt), 64'd3);
    end

    // randomized updates against the model
    for (int i = 0; i < 30; i++) begin
      logic [3:0]  s;
      logic [1:0]  a;
      logic [15:0] r, nm, al, ga, ex;
      s = 4'($urandom_range(0, 15)); a = 2'($urandom_range(0, 3));
      r = 16'($urandom); nm = 16'($urandom);
      al = 16'($urandom_range(0, 16'h01FF)); ga = 16'($urandom_range(0, 16'h01FF));
      ex = model_td(model_q[s][a], r, nm, al, ga);
      run_upd(1'b0, s, a, r, nm, al, ga, q, e, lat);
      chk($sformatf("rand%0d_done_q", i), 64'(q), 64'(ex));
      model_q[s][a] = ex;
    end
    check_all_rows("rand_row");

    // 5. same-cycle write/read of row 15, then range error on the 3-action instance
    rd_state = 4'd15;
    old_v = model_q[15][3];
    new_v = model_td(old_v, 16'h1234, 16'h0100, 16'h0100, 16'h0080);
    run_upd(1'b0, 4'd15, 2'd3, 16'h1234, 16'h0100, 16'h0100, 16'h0080, q, e, lat);
    chk("s15_done_q", 64'(q), 64'(new_v));
    chk("s15_rd_prewrite", 64'(rd_q[63:48]), 64'(old_v));
    tick();
    chk("s15_rd_postwrite", 64'(rd_q[63:48]), 64'(new_v));
    model_q[15][3] = new_v;

    run_upd(1'b1, 4'd15, 2'd2, 16'h0500, 16'h0000, 16'h0100, 16'h0000, q, e, lat);
    chk("a3x_valid_done_q", 64'(q), 64'h0500);
    chk("a3x_valid_err", 64'(e), 64'd0);
    run_upd(1'b1, 4'd15, 2'd3, 16'h0700, 16'h0000, 16'h0100, 16'h0000, q, e, lat);
    chk("a3x_oor_err", 64'(e), 64'd1);
    chk("a3x_oor_done_q", 64'(q), 64'd0);
    chk("a3x_oor_latency", 64'(lat), 64'd3);
    tick();
    chk("a3x_row15_unchanged", 64'(b_rd_q), 64'h0000_0500_0000_0000);

    // 6. reset during CALC: no done pulse, table back to INIT_Q
    upd_state = 4'd2; upd_action = 2'd2; upd_reward = 16'h0321; upd_next_max = 16'h0000;
    alpha = 16'h0100; gamma = 16'h0000;
    upd_valid = 1'b1;
    lat = 0;
    while (!upd_ready && lat < 50) begin
      tick();
      lat++;
    end
    tick();
    upd_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    chk("midrst_done_valid", 64'(done_valid), 64'd0);
    chk("midrst_upd_ready", 64'(upd_ready), 64'd0);
    rst = 1'b0;
    count_clear("midrst");
    model_clear();
    check_all_rows("midrst_row");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
